// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program counter / sequencer: op encodings,
// the op enum and the offset sign-extension helper.
package pc_seq_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_JMP  = 3'b010;
    localparam logic [2:0] OP_BR   = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [2:0] {
        OPC_NOP  = OP_NOP,
        OPC_INC  = OP_INC,
        OPC_JMP  = OP_JMP,
        OPC_BR   = OP_BR,
        OPC_CALL = OP_CALL,
        OPC_RET  = OP_RET,
        OPC_HALT = OP_HALT,
        OPC_RSVD = OP_RSVD
    } op_e;

    // Replicates bit (width-1) of val into every bit above it.
    function automatic logic [31:0] sign_extend(input logic [31:0] val, input int width);
        logic [31:0] r;
        r = val;
        for (int i = 0; i < 32; i++) begin
            if (i >= width) begin
                r[i] = val[width-1];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// LIFO return-address stack. Pushes when full and pops when empty are
// silently dropped; dout always shows the current top entry.
module pc_return_stack
    import pc_seq_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int PC_W        = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push,
    input  logic                               pop,
    input  logic [PC_W-1:0]                    din,
    output logic [PC_W-1:0]                    dout,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   level,
    output logic                               full,
    output logic                               empty
);

    localparam int LW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_W-1:0] mem_q [STACK_DEPTH];
    logic [PC_W-1:0] mem_d [STACK_DEPTH];
    logic [LW-1:0]   level_q;
    logic [LW-1:0]   level_d;
    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   rd_idx;
    logic            do_push;
    logic            do_pop;

    assign full    = (level_q == LW'(STACK_DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !push && !empty;
    assign wr_idx  = IW'(level_q);
    assign rd_idx  = IW'(level_q - LW'(1));
    assign dout    = empty ? '0 : mem_q[rd_idx];

    always_comb begin
        mem_d   = mem_q;
        level_d = level_q;
        if (do_push) begin
            mem_d[wr_idx] = din;
            level_d       = level_q + LW'(1);
        end else if (do_pop) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    // Entry contents carry no reset: only level decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
        level_q <= LW'(STACK_DEPTH));

endmodule

// File: rtl/pc_seq_unit.sv
// Program counter and sequencer: increment, jump, relative branch,
// call/return through a hardware stack, halt, with wrap or saturate at top.
module pc_seq_unit
    import pc_seq_pkg::*;
#(
    parameter int PC_W        = 4,
    parameter int OFF_W       = 4,
    parameter int STACK_DEPTH = 4,
    parameter int WRAP        = 1,
    parameter int RESET_VEC   = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic [2:0]                         op,
    input  logic [PC_W-1:0]                    target,
    input  logic [OFF_W-1:0]                   offset,
    input  logic                               cond,
    output logic [PC_W-1:0]                    pc_out,
    output logic                               halted,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               err
);

    localparam logic [PC_W-1:0] PC_MAX = '1;

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            halted_q;
    logic            halted_d;
    logic            err_q;
    logic            err_d;

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_br;
    logic [PC_W-1:0] stk_dout;
    logic            stk_push;
    logic            stk_pop;
    logic            adv;
    op_e             op_s;

    assign op_s   = op_e'(op);
    assign adv    = en && !halted_q;
    assign pc_inc = pc_q + PC_W'(1);
    // Branch target always wraps modulo 2^PC_W, independent of WRAP.
    assign pc_br  = PC_W'(32'(pc_q) + sign_extend(32'(offset), OFF_W));

    pc_return_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .PC_W        (PC_W)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .dout  (stk_dout),
        .level (stack_level),
        .full  (stack_full),
        .empty (stack_empty)
    );

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        err_d    = err_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        if (adv) begin
            unique case (op_s)
                OPC_NOP: ;
                OPC_INC: begin
                    if (pc_q == PC_MAX && WRAP == 0) begin
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
                OPC_JMP: pc_d = target;
                OPC_BR:  pc_d = cond ? pc_br : pc_inc;
                OPC_CALL: begin
                    if (stack_full) begin
                        err_d = 1'b1;
                    end else begin
                        stk_push = 1'b1;
                        pc_d     = target;
                    end
                end
                OPC_RET: begin
                    if (stack_empty) begin
                        err_d = 1'b1;
                    end else begin
                        stk_pop = 1'b1;
                        pc_d    = stk_dout;
                    end
                end
                OPC_HALT: halted_d = 1'b1;
                default:  err_d    = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= PC_W'(RESET_VEC);
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    assign pc_out = pc_q;
    assign halted = halted_q;
    assign err    = err_q;

    a_no_push_pop: assert property (@(posedge clk) disable iff (!rst_n)
        !(stk_push && stk_pop));

endmodule

// File: tb/tb_pc_seq_unit.sv
// Randomised and directed bench for pc_seq_unit, one wrapping and one
// saturating instance checked every cycle against an arithmetic model.
module tb_pc_seq_unit;

    localparam int PC_W  = 4;
    localparam int OFF_W = 4;
    localparam int DEPTH = 4;
    localparam int MOD   = 1 << PC_W;
    localparam int OMOD  = 1 << OFF_W;

    localparam logic [2:0] T_NOP  = 3'b000;
    localparam logic [2:0] T_INC  = 3'b001;
    localparam logic [2:0] T_JMP  = 3'b010;
    localparam logic [2:0] T_BR   = 3'b011;
    localparam logic [2:0] T_CALL = 3'b100;
    localparam logic [2:0] T_RET  = 3'b101;
    localparam logic [2:0] T_HALT = 3'b110;
    localparam logic [2:0] T_RSVD = 3'b111;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             en;
    logic [2:0]       op;
    logic [PC_W-1:0]  target;
    logic [OFF_W-1:0] offset;
    logic             cond;

    logic [PC_W-1:0] pc_w, pc_s;
    logic            halted_w, halted_s;
    logic [2:0]      lvl_w, lvl_s;
    logic            full_w, full_s, empty_w, empty_s, err_w, err_s;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    int m_pc   [2];
    int m_halt [2];
    int m_err  [2];
    int m_lvl  [2];
    int m_stk  [2][DEPTH];

    pc_seq_unit #(.PC_W(PC_W), .OFF_W(OFF_W), .STACK_DEPTH(DEPTH), .WRAP(1), .RESET_VEC(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en), .op(op), .target(target), .offset(offset), .cond(cond),
        .pc_out(pc_w), .halted(halted_w), .stack_level(lvl_w), .stack_full(full_w),
        .stack_empty(empty_w), .err(err_w)
    );

    pc_seq_unit #(.PC_W(PC_W), .OFF_W(OFF_W), .STACK_DEPTH(DEPTH), .WRAP(0), .RESET_VEC(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .op(op), .target(target), .offset(offset), .cond(cond),
        .pc_out(pc_s), .halted(halted_s), .stack_level(lvl_s), .stack_full(full_s),
        .stack_empty(empty_s), .err(err_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]   = 0;
            m_halt[k] = 0;
            m_err[k]  = 0;
            m_lvl[k]  = 0;
        end
    endtask

    task automatic model_step(input int k, input bit wrap);
        int off_s;
        if (m_halt[k] != 0 || en !== 1'b1) return;
        case (op)
            T_NOP: ;
            T_INC: begin
                if (m_pc[k] == MOD - 1) begin
                    if (wrap) m_pc[k] = 0;
                    else      m_halt[k] = 1;
                end else begin
                    m_pc[k] = m_pc[k] + 1;
                end
            end
            T_JMP: m_pc[k] = int'(target);
            T_BR: begin
                off_s = int'(offset);
                if (off_s >= OMOD / 2) off_s = off_s - OMOD;
                if (cond) m_pc[k] = ((m_pc[k] + off_s) % MOD + MOD) % MOD;
                else      m_pc[k] = (m_pc[k] + 1) % MOD;
            end
            T_CALL: begin
                if (m_lvl[k] == DEPTH) begin
                    m_err[k] = 1;
                end else begin
                    m_stk[k][m_lvl[k]] = (m_pc[k] + 1) % MOD;
                    m_lvl[k] = m_lvl[k] + 1;
                    m_pc[k]  = int'(target);
                end
            end
            T_RET: begin
                if (m_lvl[k] == 0) begin
                    m_err[k] = 1;
                end else begin
                    m_lvl[k] = m_lvl[k] - 1;
                    m_pc[k]  = m_stk[k][m_lvl[k]];
                end
            end
            T_HALT: m_halt[k] = 1;
            default: m_err[k] = 1;
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                model_step(0, 1'b1);
                model_step(1, 1'b0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("pc_w",    pc_w,     m_pc[0]);
                check("halt_w",  halted_w, m_halt[0]);
                check("err_w",   err_w,    m_err[0]);
                check("lvl_w",   lvl_w,    m_lvl[0]);
                check("full_w",  full_w,   m_lvl[0] == DEPTH);
                check("empty_w", empty_w,  m_lvl[0] == 0);
                check("pc_s",    pc_s,     m_pc[1]);
                check("halt_s",  halted_s, m_halt[1]);
                check("err_s",   err_s,    m_err[1]);
                check("lvl_s",   lvl_s,    m_lvl[1]);
                check("full_s",  full_s,   m_lvl[1] == DEPTH);
                check("empty_s", empty_s,  m_lvl[1] == 0);
            end
        end
    end

    task automatic do_op(input logic [2:0] o, input int t, input int off, input bit c, input bit e);
        op     = o;
        target = PC_W'(t);
        offset = OFF_W'(off);
        cond   = c;
        en     = e;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        op    = T_NOP;
        en    = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: got=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        int r;
        en = 1'b0; op = T_NOP; target = '0; offset = '0; cond = 1'b0;
        #1;
        rst_n  = 1'b0;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        check("rst_pc",    pc_w,     0);
        check("rst_halt",  halted_w, 0);
        check("rst_lvl",   lvl_w,    0);
        check("rst_empty", empty_w,  1);
        check("rst_full",  full_w,   0);
        check("rst_err",   err_w,    0);
        rst_n = 1'b1;

        // Count 17 INCs: wrap instance runs 1..15,0,1; saturating one halts at 15.
        for (int i = 0; i < 17; i++) begin
            do_op(T_INC, 0, 0, 1'b0, 1'b1);
            check("cnt_pc_w", pc_w, (i + 1) % 16);
            check("cnt_halt_w", halted_w, 0);
        end
        check("sat_pc", pc_s, 15);
        check("sat_halt", halted_s, 1);
        do_op(T_JMP, 3, 0, 1'b0, 1'b1);
        check("sat_ignore_pc", pc_s, 15);
        check("jmp_pc_w", pc_w, 3);

        reset_dut();
        for (int i = 0; i < 5; i++) do_op(T_INC, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) do_op(T_INC, 0, 0, 1'b0, 1'b0);
        check("en_hold_pc", pc_w, 5);
        do_op(T_INC, 0, 0, 1'b0, 1'b1);
        check("en_resume_pc", pc_s, 6);

        reset_dut();
        do_op(T_JMP, 3, 0, 1'b0, 1'b1);
        do_op(T_BR, 0, 4'b1110, 1'b1, 1'b1);
        check("br_neg_pc", pc_s, 1);
        do_op(T_JMP, 14, 0, 1'b0, 1'b1);
        do_op(T_BR, 0, 3, 1'b1, 1'b1);
        check("br_wrap_pc_s", pc_s, 1);
        check("br_wrap_halt_s", halted_s, 0);
        do_op(T_JMP, 5, 0, 1'b0, 1'b1);
        do_op(T_BR, 0, 4'b1110, 1'b0, 1'b1);
        check("br_nt_pc", pc_w, 6);

        reset_dut();
        do_op(T_JMP, 2, 0, 1'b0, 1'b1);
        do_op(T_CALL, 8, 0, 1'b0, 1'b1);
        check("call1_pc", pc_w, 8);  check("call1_lvl", lvl_w, 1);
        do_op(T_CALL, 12, 0, 1'b0, 1'b1);
        check("call2_pc", pc_w, 12); check("call2_lvl", lvl_w, 2);
        do_op(T_RET, 0, 0, 1'b0, 1'b1);
        check("ret1_pc", pc_w, 9);   check("ret1_lvl", lvl_w, 1);
        do_op(T_RET, 0, 0, 1'b0, 1'b1);
        check("ret2_pc", pc_w, 3);   check("ret2_lvl", lvl_w, 0);

        reset_dut();
        do_op(T_CALL, 1, 0, 1'b0, 1'b1);
        do_op(T_CALL, 2, 0, 1'b0, 1'b1);
        do_op(T_CALL, 3, 0, 1'b0, 1'b1);
        do_op(T_CALL, 7, 0, 1'b0, 1'b1);
        check("ovf_full", full_w, 1);
        check("ovf_pre_err", err_w, 0);
        do_op(T_CALL, 9, 0, 1'b0, 1'b1);
        check("ovf_pc", pc_w, 7);
        check("ovf_err", err_w, 1);
        check("ovf_lvl", lvl_w, 4);
        reset_dut();
        do_op(T_RET, 0, 0, 1'b0, 1'b1);
        check("unf_pc", pc_w, 0);
        check("unf_err", err_w, 1);

        reset_dut();
        do_op(T_CALL, 5, 0, 1'b0, 1'b1);
        do_op(T_CALL, 6, 0, 1'b0, 1'b1);
        check("pre_async_lvl", lvl_s, 2);
        op = T_CALL; target = 4'd9;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pc", pc_w, 0);
        check("async_empty", empty_w, 1);
        check("async_lvl_s", lvl_s, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_op(T_RSVD, 0, 0, 1'b0, 1'b1);
        check("rsvd_err", err_w, 1);
        check("rsvd_pc", pc_w, 0);

        reset_dut();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 79) == 0) reset_dut();
            r = $urandom_range(0, 99);
            if      (r < 25) op = T_INC;
            else if (r < 35) op = T_JMP;
            else if (r < 55) op = T_BR;
            else if (r < 73) op = T_CALL;
            else if (r < 92) op = T_RET;
            else if (r < 98) op = T_NOP;
            else if (r < 99) op = T_HALT;
            else             op = T_RSVD;
            do_op(op, int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, OMOD - 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 9) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
